// File: rtl/fir_tap_accumulator.sv
// rtl/fir_tap_accumulator.sv - sums NUM_TAPS tagged signed products into one saturated FIR sample
`timescale 1ns/1ps

module fir_tap_accumulator #(
    parameter int NUM_TAPS = 6,
    parameter int ACC_W    = 19
) (
    input  logic        iClk_12M,
    input  logic        iRst,
    input  logic        iMulValid,
    input  logic [15:0] iMulOut,
    input  logic [3:0]  iInSel,
    output logic [15:0] oFirOut,
    output logic        oFirValid,
    output logic        oSatFlag,
    output logic        oSeqErr,
    output logic [7:0]  oFrameCnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DONE
    } state_t;

    localparam logic [3:0] LAST_TAP = 4'(NUM_TAPS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    state_t                  state;
    state_t                  state_nxt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nxt;
    logic        [3:0]       exp_tap;
    logic        [3:0]       exp_tap_nxt;
    logic                    seq_err_nxt;
    logic                    emit;
    logic signed [ACC_W-1:0] prod_ext;
    logic                    sat_hi;
    logic                    sat_lo;
    logic        [15:0]      fir_sat;

    assign prod_ext = {{(ACC_W-16){iMulOut[15]}}, iMulOut};

    // The full-width sum is only clipped when the sample is emitted.
    assign sat_hi  = (acc > SAT_MAX);
    assign sat_lo  = (acc < SAT_MIN);
    assign fir_sat = sat_hi ? 16'h7FFF : (sat_lo ? 16'h8000 : acc[15:0]);

    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        exp_tap_nxt = exp_tap;
        seq_err_nxt = 1'b0;
        emit        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iMulValid) begin
                    if (iInSel == 4'd0) begin
                        acc_nxt     = prod_ext;
                        exp_tap_nxt = 4'd1;
                        state_nxt   = ST_ACCUM;
                    end else begin
                        seq_err_nxt = 1'b1;
                    end
                end
            end
            ST_ACCUM: begin
                if (iMulValid) begin
                    if (iInSel == exp_tap) begin
                        acc_nxt     = acc + prod_ext;
                        exp_tap_nxt = exp_tap + 4'd1;
                        if (iInSel == LAST_TAP) begin
                            state_nxt = ST_DONE;
                        end
                    end else if (iInSel == 4'd0) begin
                        // A stray tag 0 is treated as the start of a fresh frame.
                        seq_err_nxt = 1'b1;
                        acc_nxt     = prod_ext;
                        exp_tap_nxt = 4'd1;
                    end else begin
                        seq_err_nxt = 1'b1;
                        acc_nxt     = '0;
                        exp_tap_nxt = 4'd0;
                        state_nxt   = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                emit = 1'b1;
                // Tag 0 here opens the next frame without a bubble cycle.
                if (iMulValid && (iInSel == 4'd0)) begin
                    acc_nxt     = prod_ext;
                    exp_tap_nxt = 4'd1;
                    state_nxt   = ST_ACCUM;
                end else begin
                    seq_err_nxt = iMulValid;
                    acc_nxt     = '0;
                    exp_tap_nxt = 4'd0;
                    state_nxt   = ST_IDLE;
                end
            end
            default: begin
                acc_nxt     = '0;
                exp_tap_nxt = 4'd0;
                state_nxt   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            exp_tap   <= 4'd0;
            oFirOut   <= 16'd0;
            oFirValid <= 1'b0;
            oSatFlag  <= 1'b0;
            oSeqErr   <= 1'b0;
            oFrameCnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            exp_tap   <= exp_tap_nxt;
            oSeqErr   <= seq_err_nxt;
            oFirValid <= emit;
            if (emit) begin
                oFirOut   <= fir_sat;
                oSatFlag  <= sat_hi | sat_lo;
                oFrameCnt <= oFrameCnt + 8'd1;
            end
        end
    end

endmodule
